alu_serial_rx: RTL and testbench

- Request-side deframer for the serial ALU link. Receives the 10-bit serial words an initiator drives on din while enable_n is low, checks parity and framing, and assembles operand A, operand B and an opcode.
- Presents a validated request to the ALU core with a one-cycle valid pulse, or reports a one-cycle error instead.
- Sits between the external serial pins and the ALU datapath. It is the receive counterpart of the testbench serializer.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_word_shifter.sv | 39 +++
 rtl/alu_serial_rx.sv | 99 +++++++++
 tb/tb_alu_serial_rx.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and parity helper for the serial ALU request link.
// Used by both the deframer RTL and the serializer BFM.
package alu_pkg;

  typedef enum logic {
    DATA = 1'b0,
    CMD  = 1'b1
  } payload_type_t;

  // Deframer state encoding, kept as plain constants for legacy tools
  typedef logic [1:0] rx_state_t;
  localparam rx_state_t WAIT_A   = 2'd0;
  localparam rx_state_t WAIT_B   = 2'd1;
  localparam rx_state_t WAIT_CMD = 2'd2;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'd0,
    ERR_PARITY = 2'd1,
    ERR_SEQ    = 2'd2,
    ERR_ABORT  = 2'd3
  } rx_err_t;

  // True when the word (zero-extended) has even parity overall
  function automatic logic parity_ok(input logic [31:0] w);
    return ~^w;
  endfunction

endpackage

// File: rtl/alu_word_shifter.sv
// Serial-to-parallel word capture with a mod-(DATA_W+2) bit counter.
// Done/abort are combinational so the top registers its result on the sampling edge.
module alu_word_shifter #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable_n,
  input  logic              i_din,
  output logic              o_word_done,
  output logic [DATA_W+1:0] o_word,
  output logic              o_abort
);

  localparam int unsigned WORD_W = DATA_W + 2;
  localparam int unsigned CNT_W  = $clog2(WORD_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORD_W - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-2:0] r_shift;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_shift <= '0;
    end else if (!i_enable_n) begin
      r_shift <= {r_shift[WORD_W-3:0], i_din};
      r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
    end else begin
      r_cnt   <= '0;
    end
  end

  // The final bit is taken straight from din so the word is whole on its sampling edge
  assign o_word      = {r_shift, i_din};
  assign o_word_done = !i_enable_n && (r_cnt == LAST);
  assign o_abort     = i_enable_n && (r_cnt != '0);

endmodule

// File: rtl/alu_serial_rx.sv
// Request-side deframer: validates A, B, command words and presents one ALU request
// with a one-cycle valid pulse, or a one-cycle error pulse with a held reason code.
module alu_serial_rx
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable_n,
  input  logic              din,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] op,
  output logic              req_valid,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  logic              w_word_done;
  logic              w_abort;
  logic [DATA_W+1:0] w_word;
  logic [DATA_W-1:0] w_payload;
  payload_type_t     w_type;
  logic              w_par_ok;

  rx_state_t         r_state;
  logic [DATA_W-1:0] r_sh_a, r_sh_b;
  logic [DATA_W-1:0] r_a, r_b, r_op;
  logic              r_req, r_err;
  rx_err_t           r_err_code;

  alu_word_shifter #(.DATA_W(DATA_W)) u_shifter (
    .clk         (clk),
    .rst         (rst),
    .i_enable_n  (enable_n),
    .i_din       (din),
    .o_word_done (w_word_done),
    .o_word      (w_word),
    .o_abort     (w_abort)
  );

  assign w_type    = payload_type_t'(w_word[DATA_W+1]);
  assign w_payload = w_word[DATA_W:1];
  assign w_par_ok  = parity_ok(32'(w_word));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= WAIT_A;
      r_sh_a     <= '0;
      r_sh_b     <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_op       <= '0;
      r_req      <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_req <= 1'b0;
      r_err <= 1'b0;
      if (w_abort) begin
        r_err      <= 1'b1;
        r_err_code <= ERR_ABORT;
        r_state    <= WAIT_A;
      end else if (w_word_done) begin
        // Parity is judged before the word's type is allowed to touch the sequence
        if (!w_par_ok) begin
          r_err      <= 1'b1;
          r_err_code <= ERR_PARITY;
          r_state    <= WAIT_A;
        end else if (w_type == DATA && r_state == WAIT_A) begin
          r_sh_a  <= w_payload;
          r_state <= WAIT_B;
        end else if (w_type == DATA && r_state == WAIT_B) begin
          r_sh_b  <= w_payload;
          r_state <= WAIT_CMD;
        end else if (w_type == CMD && r_state == WAIT_CMD) begin
          r_a     <= r_sh_a;
          r_b     <= r_sh_b;
          r_op    <= w_payload;
          r_req   <= 1'b1;
          r_state <= WAIT_A;
        end else begin
          r_err      <= 1'b1;
          r_err_code <= ERR_SEQ;
          r_state    <= WAIT_A;
        end
      end
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign op        = r_op;
  assign req_valid = r_req;
  assign err_valid = r_err;
  assign err_code  = r_err_code;

endmodule

// File: tb/tb_alu_serial_rx.sv
// Directed-vector bench for alu_serial_rx with hand-computed expected words and results.
module tb_alu_serial_rx;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_n;
  logic       din;
  logic [7:0] a, b, op;
  logic       req_valid, err_valid;
  logic [1:0] err_code;

  int unsigned n_vec  = 0;
  int unsigned n_miss = 0;
  int unsigned n_req_pulses = 0;
  int unsigned n_err_pulses = 0;
  int unsigned n_both = 0;

  // Hand-encoded words: type_payload_parity
  localparam logic [9:0] W_5A     = 10'b0_01011010_0;
  localparam logic [9:0] W_5A_BAD = 10'b0_01011010_1;
  localparam logic [9:0] W_03     = 10'b0_00000011_0;
  localparam logic [9:0] C_01     = 10'b1_00000001_0;
  localparam logic [9:0] W_11     = 10'b0_00010001_0;
  localparam logic [9:0] W_22     = 10'b0_00100010_0;
  localparam logic [9:0] W_33     = 10'b0_00110011_0;
  localparam logic [9:0] W_FF     = 10'b0_11111111_0;
  localparam logic [9:0] W_80     = 10'b0_10000000_1;
  localparam logic [9:0] C_04     = 10'b1_00000100_0;

  alu_serial_rx #(.DATA_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable_n  (enable_n),
    .din       (din),
    .a         (a),
    .b         (b),
    .op        (op),
    .req_valid (req_valid),
    .err_valid (err_valid),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (req_valid) n_req_pulses++;
    if (err_valid) n_err_pulses++;
    if (req_valid && err_valid) n_both++;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives the top nbits of w, MSB first; returns 1 time unit after the last sampling edge
  task automatic send_bits(input logic [9:0] w, input int unsigned nbits);
    for (int unsigned i = 0; i < nbits; i++) begin
      enable_n = 1'b0;
      din      = w[9 - i];
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_word(input logic [9:0] w);
    send_bits(w, 10);
  endtask

  task automatic idle(input int unsigned n);
    enable_n = 1'b1;
    din      = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_req(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [7:0] eop);
    check_val({tag, "_req"}, 32'(req_valid), 32'd1);
    check_val({tag, "_err"}, 32'(err_valid), 32'd0);
    check_val({tag, "_a"},   32'(a),  32'(ea));
    check_val({tag, "_b"},   32'(b),  32'(eb));
    check_val({tag, "_op"},  32'(op), 32'(eop));
  endtask

  task automatic check_err(input string tag, input logic [1:0] ecode);
    check_val({tag, "_err"},  32'(err_valid), 32'd1);
    check_val({tag, "_code"}, 32'(err_code),  32'(ecode));
    check_val({tag, "_req"},  32'(req_valid), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    enable_n = 1'b1;
    din      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_a",    32'(a),         32'h0);
    check_val("rst_b",    32'(b),         32'h0);
    check_val("rst_op",   32'(op),        32'h0);
    check_val("rst_req",  32'(req_valid), 32'd0);
    check_val("rst_err",  32'(err_valid), 32'd0);
    check_val("rst_code", 32'(err_code),  32'd0);
    rst = 1'b0;
    idle(2);

    // Nominal back-to-back frame
    send_word(W_5A);
    check_val("nom_w1_noreq", 32'(req_valid), 32'd0);
    send_word(W_03);
    send_word(C_01);
    check_req("nom", 8'h5A, 8'h03, 8'h01);
    idle(1);
    check_val("nom_pulse_len", 32'(req_valid), 32'd0);
    check_val("nom_no_err", n_err_pulses, 32'd0);
    idle(2);

    // Parity error on A, then a good frame
    send_word(W_5A_BAD);
    check_err("par", 2'd1);
    idle(1);
    check_val("par_pulse_len", 32'(err_valid), 32'd0);
    check_val("par_code_held", 32'(err_code),  32'd1);
    send_word(W_5A);
    send_word(W_03);
    send_word(C_01);
    check_req("par_recover", 8'h5A, 8'h03, 8'h01);
    idle(2);

    // Command arriving straight after A
    send_word(W_11);
    send_word(C_01);
    check_err("seq_cmd", 2'd2);
    check_val("seq_a_kept",  32'(a),  32'h5A);
    check_val("seq_b_kept",  32'(b),  32'h03);
    check_val("seq_op_kept", 32'(op), 32'h01);
    idle(2);

    // Third data word where a command is expected
    send_word(W_11);
    send_word(W_22);
    check_val("xtra_w2_noerr", 32'(err_valid), 32'd0);
    send_word(W_33);
    check_err("xtra", 2'd2);
    idle(2);

    // Abort partway through B, then a fresh frame
    send_word(W_11);
    send_bits(W_22, 4);
    check_val("abort_pre", 32'(err_valid), 32'd0);
    idle(1);
    check_err("abort", 2'd3);
    idle(1);
    send_word(W_FF);
    send_word(W_80);
    send_word(C_04);
    check_req("abort_recover", 8'hFF, 8'h80, 8'h04);
    check_val("abort_code_held", 32'(err_code), 32'd3);
    idle(2);

    // Async reset in the middle of the command word
    send_word(W_5A);
    send_word(W_03);
    send_bits(C_01, 5);
    #2 rst = 1'b1;
    enable_n = 1'b1;
    #1;
    check_val("arst_a",    32'(a),         32'h0);
    check_val("arst_b",    32'(b),         32'h0);
    check_val("arst_op",   32'(op),        32'h0);
    check_val("arst_code", 32'(err_code),  32'd0);
    check_val("arst_req",  32'(req_valid), 32'd0);
    check_val("arst_err",  32'(err_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    check_val("arst_no_pulse", 32'(err_valid | req_valid), 32'd0);
    send_word(W_11);
    send_word(W_22);
    send_word(C_04);
    check_req("arst_recover", 8'h11, 8'h22, 8'h04);
    idle(2);

    check_val("total_req_pulses", n_req_pulses, 32'd4);
    check_val("total_err_pulses", n_err_pulses, 32'd4);
    check_val("req_err_overlap",  n_both,       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
